// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle RV32I control FSM: sequences fetch, decode, execute, memory
//   and writeback over a shared memory port with a ready handshake. Handles
//   lw, sw, R-type, I-type ALU, jal, beq/bne; anything else lands in a
//   sticky TRAP state. Also counts retired instructions.
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   op, func3, func7    : instruction fields from the IR
//   alu_zero            : ALU result is zero (branch compare)
//   mem_ready           : memory completes the current request this cycle
//   pc_write, adr_src, mem_read, mem_write, ir_write, result_src,
//   alu_src_a, alu_src_b, alu_ctrl, imm_src, reg_write : datapath controls
//   illegal             : sticky trap flag
//   instret             : retired-instruction counter (wraps)
module multicycle_control #(
  parameter int unsigned INSTRET_W = 32,
  parameter logic        BRANCH_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op,
  input  logic [2:0]           func3,
  input  logic [6:0]           func7,
  input  logic                 alu_zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           alu_ctrl,
  output logic [2:0]           imm_src,
  output logic                 reg_write,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BRANCH   = 4'd10,
    TRAP     = 4'd11
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_e               state_q, state_d;
  logic                 illegal_q, illegal_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 retire_s;
  logic                 func3_ok_s;
  logic                 func7_ok_s;
  logic                 branch_ok_s;
  logic [2:0]           exec_ctrl_s;

  // Only add/slt/or/and are implemented; other func3 codes trap in DECODE.
  assign func3_ok_s  = (func3 == 3'b000) || (func3 == 3'b010) ||
                       (func3 == 3'b110) || (func3 == 3'b111);
  assign func7_ok_s  = (func7 == 7'b0000000) || (func7 == 7'b0100000);
  assign branch_ok_s = BRANCH_EN && ((func3 == 3'b000) || (func3 == 3'b001));

  // Immediate format decode, independent of state.
  always_comb begin
    imm_src = 3'b000;
    case (op)
      OP_LOAD, OP_ITYPE: imm_src = 3'b000;
      OP_STORE:          imm_src = 3'b001;
      OP_BRANCH:         imm_src = 3'b010;
      OP_JAL:            imm_src = 3'b011;
      default:           imm_src = 3'b000;
    endcase
  end

  // ALU operation for the execute states; sub only for R-type with func7[5].
  always_comb begin
    exec_ctrl_s = ALU_ADD;
    case (func3)
      3'b000:  exec_ctrl_s = (op[5] && func7[5]) ? ALU_SUB : ALU_ADD;
      3'b010:  exec_ctrl_s = ALU_SLT;
      3'b110:  exec_ctrl_s = ALU_OR;
      3'b111:  exec_ctrl_s = ALU_AND;
      default: exec_ctrl_s = ALU_ADD;
    endcase
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_ctrl   = ALU_ADD;
    reg_write  = 1'b0;
    retire_s   = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        state_d    = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // Branch target PC+imm is computed here into ALUOut.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = (func3_ok_s && func7_ok_s) ? EXECUTER : TRAP;
          OP_ITYPE:          state_d = func3_ok_s ? EXECUTEI : TRAP;
          OP_JAL:            state_d = JAL;
          OP_BRANCH:         state_d = branch_ok_s ? BRANCH : TRAP;
          default:           state_d = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_read = 1'b1;
        adr_src  = 1'b1;
        state_d  = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire_s   = 1'b1;
        state_d    = FETCH;
      end
      MEMWRITE: begin
        mem_write = 1'b1;
        adr_src   = 1'b1;
        retire_s  = mem_ready;
        state_d   = mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_ctrl  = exec_ctrl_s;
        state_d   = ALUWB;
      end
      EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_ctrl  = exec_ctrl_s;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        retire_s  = 1'b1;
        state_d   = FETCH;
      end
      JAL: begin
        // Link value OldPC+4 goes to ALUOut while the PC takes the target.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = ALUWB;
      end
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_ctrl  = ALU_SUB;
        pc_write  = func3[0] ? ~alu_zero : alu_zero;
        retire_s  = 1'b1;
        state_d   = FETCH;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = TRAP;
      end
    endcase
  end

  // Sticky trap flag and wrapping retire counter.
  always_comb begin
    illegal_d = illegal_q | (state_q == TRAP);
    instret_d = retire_s ? (instret_q + INSTRET_W'(1)) : instret_q;
  end

  // State, trap flag and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1;
  logic [6:0] op, func7;
  logic [2:0] func3;
  logic       alu_zero, mem_ready;
  logic [6:0] cur_op, cur_f7;
  logic [2:0] cur_f3;

  logic        pc_write0, adr_src0, mem_read0, mem_write0, ir_write0, reg_write0, illegal0;
  logic [1:0]  result_src0, alu_src_a0, alu_src_b0;
  logic [2:0]  alu_ctrl0, imm_src0;
  logic [31:0] instret0;
  logic        pc_write1, adr_src1, mem_read1, mem_write1, ir_write1, reg_write1, illegal1;
  logic [1:0]  result_src1, alu_src_a1, alu_src_b1;
  logic [2:0]  alu_ctrl1, imm_src1;
  logic [3:0]  instret1;

  logic [14:0] sig0, sig1;
  assign sig0 = {pc_write0, adr_src0, mem_read0, mem_write0, ir_write0, result_src0,
                 alu_src_a0, alu_src_b0, alu_ctrl0, reg_write0};
  assign sig1 = {pc_write1, adr_src1, mem_read1, mem_write1, ir_write1, result_src1,
                 alu_src_a1, alu_src_b1, alu_ctrl1, reg_write1};

  // {pc_write, adr_src, mem_read, mem_write, ir_write, result_src, a, b, alu_ctrl, reg_write}
  localparam logic [14:0] S_FETCH0 = 15'b0_0_1_0_0_10_00_10_000_0;
  localparam logic [14:0] S_FETCH1 = 15'b1_0_1_0_1_10_00_10_000_0;
  localparam logic [14:0] S_DEC    = 15'b0_0_0_0_0_00_01_01_000_0;
  localparam logic [14:0] S_ADD_I  = 15'b0_0_0_0_0_00_10_01_000_0;
  localparam logic [14:0] S_MRD    = 15'b0_1_1_0_0_00_00_00_000_0;
  localparam logic [14:0] S_MWB    = 15'b0_0_0_0_0_01_00_00_000_1;
  localparam logic [14:0] S_MWR    = 15'b0_1_0_1_0_00_00_00_000_0;
  localparam logic [14:0] S_SUB    = 15'b0_0_0_0_0_00_10_00_001_0;
  localparam logic [14:0] S_SLT    = 15'b0_0_0_0_0_00_10_00_101_0;
  localparam logic [14:0] S_AWB    = 15'b0_0_0_0_0_00_00_00_000_1;
  localparam logic [14:0] S_JAL    = 15'b1_0_0_0_0_00_01_10_000_0;
  localparam logic [14:0] S_BR_T   = 15'b1_0_0_0_0_00_10_00_001_0;
  localparam logic [14:0] S_BR_N   = 15'b0_0_0_0_0_00_10_00_001_0;
  localparam logic [14:0] S_TRAP   = 15'b0_0_0_0_0_00_00_00_000_0;

  int n_vec = 0;
  int n_err = 0;

  multicycle_control dut0 (
    .clk(clk), .rst(rst0), .op(op), .func3(func3), .func7(func7),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_write(pc_write0), .adr_src(adr_src0), .mem_read(mem_read0),
    .mem_write(mem_write0), .ir_write(ir_write0), .result_src(result_src0),
    .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .alu_ctrl(alu_ctrl0),
    .imm_src(imm_src0), .reg_write(reg_write0), .illegal(illegal0),
    .instret(instret0)
  );

  multicycle_control #(.INSTRET_W(4), .BRANCH_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst1), .op(op), .func3(func3), .func7(func7),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_write(pc_write1), .adr_src(adr_src1), .mem_read(mem_read1),
    .mem_write(mem_write1), .ir_write(ir_write1), .result_src(result_src1),
    .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1), .alu_ctrl(alu_ctrl1),
    .imm_src(imm_src1), .reg_write(reg_write1), .illegal(illegal1),
    .instret(instret1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply the current instruction plus rdy/zero at the falling edge, then
  // compare the control signature of the selected instance.
  task automatic step(input logic rdy, input logic z, input logic [14:0] exp,
                      input string tag, input int which);
    @(negedge clk);
    op        = cur_op;
    func3     = cur_f3;
    func7     = cur_f7;
    mem_ready = rdy;
    alu_zero  = z;
    #1;
    chk(tag, 32'((which == 0) ? sig0 : sig1), 32'(exp));
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    cur_op = o;
    cur_f3 = f3;
    cur_f7 = f7;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    op = 7'd0; func3 = 3'd0; func7 = 7'd0; alu_zero = 1'b0; mem_ready = 1'b0;
    set_instr(7'd0, 3'd0, 7'd0);

    // Reset state
    step(1'b0, 1'b0, S_FETCH0, "rst_sig", 0);
    chk("rst_instret", instret0, 32'd0);
    chk("rst_illegal", 32'(illegal0), 32'd0);
    step(1'b0, 1'b0, S_FETCH0, "rst_sig1", 1);
    rst0 = 1'b0; rst1 = 1'b0;

    // lw with two wait states in FETCH and MEMREAD
    set_instr(7'b0000011, 3'b010, 7'd0);
    step(1'b0, 1'b0, S_FETCH0, "lw_f0", 0);
    step(1'b0, 1'b0, S_FETCH0, "lw_f1", 0);
    step(1'b1, 1'b0, S_FETCH1, "lw_f2", 0);
    step(1'b1, 1'b0, S_DEC,    "lw_dec", 0);
    chk("lw_imm", 32'(imm_src0), 32'd0);
    step(1'b1, 1'b0, S_ADD_I,  "lw_adr", 0);
    step(1'b0, 1'b0, S_MRD,    "lw_rd0", 0);
    step(1'b0, 1'b0, S_MRD,    "lw_rd1", 0);
    step(1'b1, 1'b0, S_MRD,    "lw_rd2", 0);
    step(1'b1, 1'b0, S_MWB,    "lw_wb", 0);
    chk("lw_instret_pre", instret0, 32'd0);

    // sw
    set_instr(7'b0100011, 3'b010, 7'd0);
    step(1'b1, 1'b0, S_FETCH1, "sw_fetch", 0);
    chk("lw_instret", instret0, 32'd1);
    step(1'b1, 1'b0, S_DEC,    "sw_dec", 0);
    chk("sw_imm", 32'(imm_src0), 32'd1);
    step(1'b1, 1'b0, S_ADD_I,  "sw_adr", 0);
    step(1'b1, 1'b0, S_MWR,    "sw_wr", 0);

    // R-type sub (fetch right after MEMWRITE shows sw took 4 cycles)
    set_instr(7'b0110011, 3'b000, 7'b0100000);
    step(1'b1, 1'b0, S_FETCH1, "sub_fetch", 0);
    chk("sw_instret", instret0, 32'd2);
    step(1'b1, 1'b0, S_DEC,    "sub_dec", 0);
    step(1'b1, 1'b0, S_SUB,    "sub_exec", 0);
    step(1'b1, 1'b0, S_AWB,    "sub_wb", 0);

    // R-type slt
    set_instr(7'b0110011, 3'b010, 7'b0000000);
    step(1'b1, 1'b0, S_FETCH1, "slt_fetch", 0);
    chk("sub_instret", instret0, 32'd3);
    step(1'b1, 1'b0, S_DEC,    "slt_dec", 0);
    step(1'b1, 1'b0, S_SLT,    "slt_exec", 0);
    step(1'b1, 1'b0, S_AWB,    "slt_wb", 0);

    // jal
    set_instr(7'b1101111, 3'b000, 7'd0);
    step(1'b1, 1'b0, S_FETCH1, "jal_fetch", 0);
    chk("slt_instret", instret0, 32'd4);
    step(1'b1, 1'b0, S_DEC,    "jal_dec", 0);
    chk("jal_imm", 32'(imm_src0), 32'd3);
    step(1'b1, 1'b0, S_JAL,    "jal_jal", 0);
    step(1'b1, 1'b0, S_AWB,    "jal_wb", 0);

    // beq taken; the BRANCH_EN=0 instance traps instead
    set_instr(7'b1100011, 3'b000, 7'd0);
    step(1'b1, 1'b1, S_FETCH1, "beq_fetch", 0);
    chk("jal_instret", instret0, 32'd5);
    step(1'b1, 1'b1, S_DEC,    "beq_dec", 0);
    chk("beq_imm", 32'(imm_src0), 32'd2);
    step(1'b1, 1'b1, S_BR_T,   "beq_br", 0);
    chk("nobr_trap", 32'(sig1), 32'(S_TRAP));
    chk("nobr_illegal_pre", 32'(illegal1), 32'd0);

    // bne with alu_zero=1 is not taken
    set_instr(7'b1100011, 3'b001, 7'd0);
    step(1'b1, 1'b1, S_FETCH1, "bne_fetch", 0);
    chk("nobr_illegal", 32'(illegal1), 32'd1);
    chk("beq_instret", instret0, 32'd6);
    step(1'b1, 1'b1, S_DEC,    "bne_dec", 0);
    step(1'b1, 1'b1, S_BR_N,   "bne_br", 0);

    // Reset in the middle of a load
    set_instr(7'b0000011, 3'b010, 7'd0);
    step(1'b1, 1'b0, S_FETCH1, "mid_fetch", 0);
    chk("bne_instret", instret0, 32'd7);
    step(1'b1, 1'b0, S_DEC,    "mid_dec", 0);
    step(1'b1, 1'b0, S_ADD_I,  "mid_adr", 0);
    step(1'b0, 1'b0, S_MRD,    "mid_rd", 0);
    rst0 = 1'b1; rst1 = 1'b1;
    step(1'b0, 1'b0, S_FETCH0, "mid_rst", 0);
    chk("mid_instret", instret0, 32'd0);
    chk("mid_rst1", 32'(sig1), 32'(S_FETCH0));
    chk("mid_illegal1", 32'(illegal1), 32'd0);
    rst0 = 1'b0; rst1 = 1'b0;

    // Illegal opcode, sticky trap, then recovery
    set_instr(7'b1110011, 3'b000, 7'd0);
    step(1'b1, 1'b0, S_FETCH1, "ill_fetch", 0);
    step(1'b1, 1'b0, S_DEC,    "ill_dec", 0);
    step(1'b1, 1'b0, S_TRAP,   "ill_trap", 0);
    chk("ill_first", 32'(illegal0), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, S_TRAP, "ill_hold", 0);
      chk("ill_sticky", 32'(illegal0), 32'd1);
    end
    rst0 = 1'b1; rst1 = 1'b1;
    step(1'b0, 1'b0, S_FETCH0, "ill_rst", 0);
    chk("ill_rst_flag", 32'(illegal0), 32'd0);
    chk("ill_rst_instret", instret0, 32'd0);
    rst0 = 1'b0; rst1 = 1'b0;

    // 16 addi on the 4-bit counter instance: 15 wraps to 0
    set_instr(7'b0010011, 3'b000, 7'd0);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, S_FETCH1, "addi_fetch", 1);
      chk("addi_cnt", 32'(instret1), 32'(i));
      step(1'b1, 1'b0, S_DEC,   "addi_dec", 1);
      step(1'b1, 1'b0, S_ADD_I, "addi_exec", 1);
      step(1'b1, 1'b0, S_AWB,   "addi_wb", 1);
    end
    step(1'b1, 1'b0, S_FETCH1, "wrap_fetch", 1);
    chk("wrap_cnt", 32'(instret1), 32'd0);
    chk("nowrap_cnt", instret0, 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
